idex_hazard_reg: RTL and testbench
==================================

IDEX_HAZARD_REG -- requirements
Module: idex_hazard_reg

Interface
REQ-001 Parameter DATA_W, 32, width of the operand, immediate and PC+4 data fields.
REQ-002 Parameter CTRL_W, 12, width of the packed control bus; the field layout is defined in the shared package.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port IFID_Rs and IFID_Rt, input, 5 each, source register fields of the instruction in ID.
REQ-006 Port ID_RegWriteAddr, input, 5, destination register of the instruction in ID.
REQ-007 Port ID_Ctrl, input, CTRL_W, packed decoded control for the ID instruction: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUCtrl[4:0], spare[1:0].
REQ-008 Port ID_PCSrc, input, 3, PC source of the ID instruction; 3'b010 denotes jr/jalr.
REQ-009 Port ID_RsData, ID_RtData, ID_Imm and ID_PC4, input, DATA_W each, ID-stage data fields.
REQ-010 Port EXMEM_MemRead, input, 1, load in MEM stage.
REQ-011 Port EXMEM_RegWriteAddr, input, 5, destination register of the MEM-stage instruction.
REQ-012 Port Flush, input, 1, kill the ID instruction (taken branch or jump redirect).
REQ-013 Port IDEX_Rs, IDEX_Rt and IDEX_RegWriteAddr, output, 5 each, registered register fields for the forwarding unit.
REQ-014 Port IDEX_RegWrite and IDEX_MemRead, output, 1 each, registered control bits.
REQ-015 Port IDEX_Ctrl, output, CTRL_W, registered full control bus.
REQ-016 Port IDEX_RsData, IDEX_RtData, IDEX_Imm and IDEX_PC4, output, DATA_W each, registered data fields.
REQ-017 Port Stall, output, 1, combinational hold request for the PC and IF/ID registers.
REQ-018 Port StallCycles, output, 16, saturating count of stall cycles.

Function
REQ-019 LoadUse SHALL be asserted when IDEX_MemRead=1, IDEX_RegWriteAddr!=0, and IDEX_RegWriteAddr equals IFID_Rs or IFID_Rt.
REQ-020 JrLoadEX SHALL be asserted when ID_PCSrc=3'b010, IDEX_MemRead=1, IDEX_RegWriteAddr=IFID_Rs, and IFID_Rs!=0.
REQ-021 JrLoadMEM SHALL be asserted when ID_PCSrc=3'b010, EXMEM_MemRead=1, EXMEM_RegWriteAddr=IFID_Rs, and IFID_Rs!=0.
REQ-022 The FSM SHALL have two states, RUN and HOLD; in RUN, Stall = (LoadUse|JrLoadEX|JrLoadMEM) & ~Flush.
REQ-023 In RUN, if JrLoadEX & ~Flush, the next state SHALL be HOLD; otherwise the state SHALL remain RUN.
REQ-024 In HOLD, Stall SHALL be ~Flush and the next state SHALL be RUN; this yields exactly 2 stall cycles for a jr/jalr immediately after a load.
REQ-025 On each edge with Stall=1 or Flush=1, the IDEX registers SHALL load a bubble: every control bit and register field cleared to 0; data fields are don't-care and SHALL be cleared to 0.
REQ-026 On each edge with Stall=0 and Flush=0, every IDEX output register SHALL capture its corresponding ID input (latency 1 cycle).
REQ-027 Flush SHALL take priority over any stall: Stall=0, a bubble is loaded, and the next state is RUN.
REQ-028 StallCycles SHALL increment on each edge with Stall=1 and SHALL saturate at 16'hFFFF.
REQ-029 Hazards SHALL be ignored when the destination register is $0; no stall SHALL be raised for it.

Reset
REQ-030 When reset=0, all IDEX outputs SHALL be 0, the state SHALL be RUN, and StallCycles SHALL be 0, asynchronously and independent of clk.
REQ-031 Reset asserted mid-HOLD SHALL abandon the pending stall; the first edge after reset release SHALL be in RUN.

Structure
REQ-032 The shared package SHALL hold the state encoding (RUN=0, HOLD=1), the ID_Ctrl field bit positions, and the constant PCSRC_JR=3'b010.
REQ-033 A single sub-module, hazard_detect, SHALL compute LoadUse, JrLoadEX and JrLoadMEM combinationally; the FSM, registers and counter SHALL reside in idex_hazard_reg.

Verification
REQ-034 Scenario: lw $8 in EX, ID add with Rs=8 -> Stall=1 for 1 cycle, IDEX_Ctrl=0 next cycle, then add captured; StallCycles=1.
REQ-035 Scenario: lw $31 in EX, ID jr with Rs=31 -> Stall=1 for 2 cycles (RUN->HOLD->RUN), then jr captured; StallCycles=2.
REQ-036 Scenario: lw $0 in EX, ID add with Rs=0 -> Stall=0, add captured next edge.
REQ-037 Scenario: load-use stall and Flush=1 in the same cycle -> Stall=0, bubble loaded, state RUN.
REQ-038 Scenario: reset=0 asserted while in HOLD between edges -> all outputs 0 immediately; after release, ID add is captured with no stall.
REQ-039 Scenario: force 65537 stall cycles -> StallCycles holds at 16'hFFFF.

Source files
------------

// File: rtl/idex_hazard_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: FSM encoding,
// control-bus field positions and the jr/jalr PC-source code.
package idex_hazard_reg_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bit positions inside the 12-bit packed control bus
  localparam int CTRL_REGWRITE  = 11;
  localparam int CTRL_MEMREAD   = 10;
  localparam int CTRL_MEMWRITE  = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_ALUCTRL_HI = 6;
  localparam int CTRL_ALUCTRL_LO = 2;
  localparam int CTRL_SPARE_HI  = 1;
  localparam int CTRL_SPARE_LO  = 0;

  localparam logic [2:0] PCSRC_JR = 3'b010;

endpackage

// File: rtl/idex_hazard_reg_hazard_detect.sv
// Combinational hazard detection: load-use against EX, and jr/jalr
// source-register dependencies on loads sitting in EX or MEM.
module hazard_detect
  import idex_hazard_reg_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic [2:0] id_pcsrc,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rd,
  input  logic       exmem_mem_read,
  input  logic [4:0] exmem_rd,
  output logic       load_use,
  output logic       jr_load_ex,
  output logic       jr_load_mem
);

  logic is_jr;

  assign is_jr = (id_pcsrc == PCSRC_JR);

  // A destination of $0 never creates a real dependency
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

  assign jr_load_ex = is_jr && idex_mem_read && (idex_rd == ifid_rs) &&
                      (ifid_rs != 5'd0);

  assign jr_load_mem = is_jr && exmem_mem_read && (exmem_rd == ifid_rs) &&
                       (ifid_rs != 5'd0);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with stall/flush bubble insertion, a two-state
// FSM that stretches jr-after-load to two stall cycles, and a stall counter.
module idex_hazard_reg
  import idex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_Rs,
  input  logic [4:0]        IFID_Rt,
  input  logic [4:0]        ID_RegWriteAddr,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [2:0]        ID_PCSrc,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic              EXMEM_MemRead,
  input  logic [4:0]        EXMEM_RegWriteAddr,
  input  logic              Flush,
  output logic [4:0]        IDEX_Rs,
  output logic [4:0]        IDEX_Rt,
  output logic [4:0]        IDEX_RegWriteAddr,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic [DATA_W-1:0] IDEX_RsData,
  output logic [DATA_W-1:0] IDEX_RtData,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic [DATA_W-1:0] IDEX_PC4,
  output logic              Stall,
  output logic [15:0]       StallCycles
);

  state_t state;
  logic   load_use;
  logic   jr_load_ex;
  logic   jr_load_mem;
  logic   bubble;

  hazard_detect u_hazard_detect (
    .ifid_rs        (IFID_Rs),
    .ifid_rt        (IFID_Rt),
    .id_pcsrc       (ID_PCSrc),
    .idex_mem_read  (IDEX_MemRead),
    .idex_rd        (IDEX_RegWriteAddr),
    .exmem_mem_read (EXMEM_MemRead),
    .exmem_rd       (EXMEM_RegWriteAddr),
    .load_use       (load_use),
    .jr_load_ex     (jr_load_ex),
    .jr_load_mem    (jr_load_mem)
  );

  assign IDEX_RegWrite = IDEX_Ctrl[CTRL_REGWRITE];
  assign IDEX_MemRead  = IDEX_Ctrl[CTRL_MEMREAD];

  // HOLD covers the second cycle of jr-after-load unconditionally, since
  // the load has moved on to MEM by then; a flush always wins.
  always_comb begin
    Stall = 1'b0;
    case (state)
      RUN:     Stall = (load_use | jr_load_ex | jr_load_mem) & ~Flush;
      HOLD:    Stall = ~Flush;
      default: Stall = 1'b0;
    endcase
  end

  assign bubble = Stall | Flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= (jr_load_ex && !Flush) ? HOLD : RUN;
        HOLD:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IDEX_Rs           <= '0;
      IDEX_Rt           <= '0;
      IDEX_RegWriteAddr <= '0;
      IDEX_Ctrl         <= '0;
      IDEX_RsData       <= '0;
      IDEX_RtData       <= '0;
      IDEX_Imm          <= '0;
      IDEX_PC4          <= '0;
    end else if (bubble) begin
      IDEX_Rs           <= '0;
      IDEX_Rt           <= '0;
      IDEX_RegWriteAddr <= '0;
      IDEX_Ctrl         <= '0;
      IDEX_RsData       <= '0;
      IDEX_RtData       <= '0;
      IDEX_Imm          <= '0;
      IDEX_PC4          <= '0;
    end else begin
      IDEX_Rs           <= IFID_Rs;
      IDEX_Rt           <= IFID_Rt;
      IDEX_RegWriteAddr <= ID_RegWriteAddr;
      IDEX_Ctrl         <= ID_Ctrl;
      IDEX_RsData       <= ID_RsData;
      IDEX_RtData       <= ID_RtData;
      IDEX_Imm          <= ID_Imm;
      IDEX_PC4          <= ID_PC4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCycles <= '0;
    end else if (Stall && (StallCycles != 16'hFFFF)) begin
      StallCycles <= StallCycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed self-checking bench for idex_hazard_reg; each task covers one scenario.
module tb_idex_hazard_reg;

  localparam logic [11:0] CTRL_LW  = 12'hD80;
  localparam logic [11:0] CTRL_ADD = 12'h808;
  localparam logic [11:0] CTRL_SUB = 12'h80C;
  localparam logic [2:0]  JR       = 3'b010;

  logic        clk;
  logic        reset;
  logic [4:0]  IFID_Rs, IFID_Rt, ID_RegWriteAddr;
  logic [11:0] ID_Ctrl;
  logic [2:0]  ID_PCSrc;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm, ID_PC4;
  logic        EXMEM_MemRead;
  logic [4:0]  EXMEM_RegWriteAddr;
  logic        Flush;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_RegWriteAddr;
  logic        IDEX_RegWrite, IDEX_MemRead;
  logic [11:0] IDEX_Ctrl;
  logic [31:0] IDEX_RsData, IDEX_RtData, IDEX_Imm, IDEX_PC4;
  logic        Stall;
  logic [15:0] StallCycles;

  int checks = 0;
  int passes = 0;

  idex_hazard_reg dut (
    .clk                (clk),
    .reset              (reset),
    .IFID_Rs            (IFID_Rs),
    .IFID_Rt            (IFID_Rt),
    .ID_RegWriteAddr    (ID_RegWriteAddr),
    .ID_Ctrl            (ID_Ctrl),
    .ID_PCSrc           (ID_PCSrc),
    .ID_RsData          (ID_RsData),
    .ID_RtData          (ID_RtData),
    .ID_Imm             (ID_Imm),
    .ID_PC4             (ID_PC4),
    .EXMEM_MemRead      (EXMEM_MemRead),
    .EXMEM_RegWriteAddr (EXMEM_RegWriteAddr),
    .Flush              (Flush),
    .IDEX_Rs            (IDEX_Rs),
    .IDEX_Rt            (IDEX_Rt),
    .IDEX_RegWriteAddr  (IDEX_RegWriteAddr),
    .IDEX_RegWrite      (IDEX_RegWrite),
    .IDEX_MemRead       (IDEX_MemRead),
    .IDEX_Ctrl          (IDEX_Ctrl),
    .IDEX_RsData        (IDEX_RsData),
    .IDEX_RtData        (IDEX_RtData),
    .IDEX_Imm           (IDEX_Imm),
    .IDEX_PC4           (IDEX_PC4),
    .Stall              (Stall),
    .StallCycles        (StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [11:0] ctrl, input logic [2:0] pcsrc, input logic [31:0] base);
    IFID_Rs = rs;
    IFID_Rt = rt;
    ID_RegWriteAddr = rd;
    ID_Ctrl = ctrl;
    ID_PCSrc = pcsrc;
    ID_RsData = base;
    ID_RtData = base + 32'd1;
    ID_Imm = base + 32'd2;
    ID_PC4 = base + 32'd3;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    EXMEM_MemRead = 1'b0;
    EXMEM_RegWriteAddr = 5'd0;
    Flush = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 12'h000, 3'b000, 32'h0);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    EXMEM_MemRead = 1'b0;
    EXMEM_RegWriteAddr = 5'd0;
    Flush = 1'b0;
    set_id(5'd3, 5'd4, 5'd5, CTRL_ADD, 3'b000, 32'h1111_0000);
    checks++;
    if ({IDEX_Rs, IDEX_Rt, IDEX_RegWriteAddr, IDEX_Ctrl, IDEX_RsData, IDEX_PC4, StallCycles} !== '0)
      $display("[TB] FAIL reset_outputs: got ctrl=%h rsdata=%h cnt=%0d expected all 0", IDEX_Ctrl, IDEX_RsData, StallCycles);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (IDEX_RsData !== 32'h1111_0000 || IDEX_Ctrl !== CTRL_ADD)
      $display("[TB] FAIL reset_capture: got rsdata=%h ctrl=%h expected 11110000/%h", IDEX_RsData, IDEX_Ctrl, CTRL_ADD);
    else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (IDEX_RsData !== 32'h0 || IDEX_Ctrl !== 12'h0 || IDEX_RegWrite !== 1'b0)
      $display("[TB] FAIL reset_async: got rsdata=%h ctrl=%h expected 0", IDEX_RsData, IDEX_Ctrl);
    else passes++;
  endtask

  task automatic test_capture();
    do_reset();
    set_id(5'd1, 5'd2, 5'd3, CTRL_ADD, 3'b000, 32'hA000_0000);
    tick();
    set_id(5'd4, 5'd5, 5'd6, CTRL_SUB, 3'b000, 32'hB000_0010);
    checks++;
    if (IDEX_Rs !== 5'd1 || IDEX_Rt !== 5'd2 || IDEX_RegWriteAddr !== 5'd3 || IDEX_Ctrl !== CTRL_ADD ||
        IDEX_RsData !== 32'hA000_0000 || IDEX_RtData !== 32'hA000_0001 || IDEX_Imm !== 32'hA000_0002 ||
        IDEX_PC4 !== 32'hA000_0003 || IDEX_RegWrite !== 1'b1 || IDEX_MemRead !== 1'b0)
      $display("[TB] FAIL capture_a: got rs=%0d rt=%0d rd=%0d ctrl=%h imm=%h pc4=%h expected 1/2/3/%h/a0000002/a0000003",
               IDEX_Rs, IDEX_Rt, IDEX_RegWriteAddr, IDEX_Ctrl, IDEX_Imm, IDEX_PC4, CTRL_ADD);
    else passes++;
    tick();
    checks++;
    if (IDEX_Rs !== 5'd4 || IDEX_Rt !== 5'd5 || IDEX_RegWriteAddr !== 5'd6 || IDEX_Ctrl !== CTRL_SUB ||
        IDEX_RtData !== 32'hB000_0011 || IDEX_PC4 !== 32'hB000_0013)
      $display("[TB] FAIL capture_b: got rs=%0d rt=%0d rd=%0d ctrl=%h rtdata=%h expected 4/5/6/%h/b0000011",
               IDEX_Rs, IDEX_Rt, IDEX_RegWriteAddr, IDEX_Ctrl, IDEX_RtData, CTRL_SUB);
    else passes++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd29, 5'd8, 5'd8, CTRL_LW, 3'b000, 32'h100);
    tick();
    checks++;
    if (IDEX_MemRead !== 1'b1 || IDEX_RegWriteAddr !== 5'd8)
      $display("[TB] FAIL lu_lw_in_ex: got memread=%0b rd=%0d expected 1/8", IDEX_MemRead, IDEX_RegWriteAddr);
    else passes++;
    // Dependency through Rt as well as Rs
    set_id(5'd7, 5'd8, 5'd10, CTRL_ADD, 3'b000, 32'h200);
    checks++;
    if (Stall !== 1'b1)
      $display("[TB] FAIL lu_stall_rt: got %0b expected 1", Stall);
    else passes++;
    set_id(5'd8, 5'd9, 5'd10, CTRL_ADD, 3'b000, 32'h200);
    checks++;
    if (Stall !== 1'b1)
      $display("[TB] FAIL lu_stall: got %0b expected 1", Stall);
    else passes++;
    tick();
    checks++;
    if (IDEX_Ctrl !== 12'h0 || IDEX_RegWriteAddr !== 5'd0 || Stall !== 1'b0)
      $display("[TB] FAIL lu_bubble: got ctrl=%h rd=%0d stall=%0b expected 0/0/0", IDEX_Ctrl, IDEX_RegWriteAddr, Stall);
    else passes++;
    tick();
    checks++;
    if (IDEX_Ctrl !== CTRL_ADD || IDEX_Rs !== 5'd8 || IDEX_RsData !== 32'h200 || StallCycles !== 16'd1)
      $display("[TB] FAIL lu_after: got ctrl=%h rs=%0d rsdata=%h cnt=%0d expected %h/8/200/1",
               IDEX_Ctrl, IDEX_Rs, IDEX_RsData, StallCycles, CTRL_ADD);
    else passes++;
  endtask

  task automatic test_jr_after_load();
    do_reset();
    set_id(5'd29, 5'd31, 5'd31, CTRL_LW, 3'b000, 32'h300);
    tick();
    set_id(5'd31, 5'd0, 5'd0, 12'h000, JR, 32'h400);
    checks++;
    if (Stall !== 1'b1)
      $display("[TB] FAIL jr_stall1: got %0b expected 1", Stall);
    else passes++;
    tick();
    // Load in MEM is left invisible here, so only HOLD can keep the stall
    checks++;
    if (Stall !== 1'b1 || IDEX_Ctrl !== 12'h0)
      $display("[TB] FAIL jr_stall2: got stall=%0b ctrl=%h expected 1/0", Stall, IDEX_Ctrl);
    else passes++;
    tick();
    checks++;
    if (Stall !== 1'b0 || IDEX_Ctrl !== 12'h0)
      $display("[TB] FAIL jr_release: got stall=%0b ctrl=%h expected 0/0", Stall, IDEX_Ctrl);
    else passes++;
    tick();
    checks++;
    if (IDEX_Rs !== 5'd31 || IDEX_RsData !== 32'h400 || StallCycles !== 16'd2)
      $display("[TB] FAIL jr_after: got rs=%0d rsdata=%h cnt=%0d expected 31/400/2", IDEX_Rs, IDEX_RsData, StallCycles);
    else passes++;
  endtask

  task automatic test_jr_load_mem();
    do_reset();
    EXMEM_MemRead = 1'b1;
    EXMEM_RegWriteAddr = 5'd5;
    set_id(5'd5, 5'd0, 5'd0, 12'h000, JR, 32'h500);
    checks++;
    if (Stall !== 1'b1)
      $display("[TB] FAIL jr_mem_stall: got %0b expected 1", Stall);
    else passes++;
    set_id(5'd5, 5'd0, 5'd0, 12'h000, 3'b000, 32'h500);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL jr_mem_notjr: got %0b expected 0", Stall);
    else passes++;
    EXMEM_RegWriteAddr = 5'd0;
    set_id(5'd0, 5'd0, 5'd0, 12'h000, JR, 32'h500);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL jr_mem_zero: got %0b expected 0", Stall);
    else passes++;
    EXMEM_MemRead = 1'b0;
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(5'd29, 5'd0, 5'd0, CTRL_LW, 3'b000, 32'h600);
    tick();
    set_id(5'd0, 5'd0, 5'd12, CTRL_ADD, 3'b000, 32'h700);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL zero_stall: got %0b expected 0", Stall);
    else passes++;
    tick();
    checks++;
    if (IDEX_Ctrl !== CTRL_ADD || IDEX_RegWriteAddr !== 5'd12 || StallCycles !== 16'd0)
      $display("[TB] FAIL zero_capture: got ctrl=%h rd=%0d cnt=%0d expected %h/12/0", IDEX_Ctrl, IDEX_RegWriteAddr, StallCycles, CTRL_ADD);
    else passes++;
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_id(5'd29, 5'd8, 5'd8, CTRL_LW, 3'b000, 32'h800);
    tick();
    Flush = 1'b1;
    set_id(5'd8, 5'd9, 5'd10, CTRL_ADD, 3'b000, 32'h900);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL flush_lu_stall: got %0b expected 0", Stall);
    else passes++;
    tick();
    checks++;
    if (IDEX_Ctrl !== 12'h0 || IDEX_Rs !== 5'd0 || IDEX_RsData !== 32'h0 || StallCycles !== 16'd0)
      $display("[TB] FAIL flush_bubble: got ctrl=%h rs=%0d rsdata=%h cnt=%0d expected 0/0/0/0", IDEX_Ctrl, IDEX_Rs, IDEX_RsData, StallCycles);
    else passes++;
    // jr-after-load killed by a flush must not leave the FSM in HOLD
    Flush = 1'b0;
    set_id(5'd29, 5'd31, 5'd31, CTRL_LW, 3'b000, 32'hA00);
    tick();
    Flush = 1'b1;
    set_id(5'd31, 5'd0, 5'd0, 12'h000, JR, 32'hB00);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL flush_jr_stall: got %0b expected 0", Stall);
    else passes++;
    tick();
    Flush = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL flush_state_run: got %0b expected 0", Stall);
    else passes++;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    set_id(5'd29, 5'd31, 5'd31, CTRL_LW, 3'b000, 32'hC00);
    tick();
    set_id(5'd31, 5'd0, 5'd0, 12'h000, JR, 32'hD00);
    tick();
    checks++;
    if (Stall !== 1'b1 || StallCycles !== 16'd1)
      $display("[TB] FAIL hold_entered: got stall=%0b cnt=%0d expected 1/1", Stall, StallCycles);
    else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (StallCycles !== 16'd0 || IDEX_Ctrl !== 12'h0 || IDEX_Rs !== 5'd0)
      $display("[TB] FAIL hold_reset_async: got cnt=%0d ctrl=%h expected 0/0", StallCycles, IDEX_Ctrl);
    else passes++;
    reset = 1'b1;
    set_id(5'd9, 5'd11, 5'd13, CTRL_ADD, 3'b000, 32'hE00);
    checks++;
    if (Stall !== 1'b0)
      $display("[TB] FAIL hold_reset_nostall: got %0b expected 0", Stall);
    else passes++;
    tick();
    checks++;
    if (IDEX_Ctrl !== CTRL_ADD || IDEX_Rs !== 5'd9 || IDEX_RsData !== 32'hE00)
      $display("[TB] FAIL hold_reset_capture: got ctrl=%h rs=%0d rsdata=%h expected %h/9/e00", IDEX_Ctrl, IDEX_Rs, IDEX_RsData, CTRL_ADD);
    else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    EXMEM_MemRead = 1'b1;
    EXMEM_RegWriteAddr = 5'd5;
    set_id(5'd5, 5'd0, 5'd0, 12'h000, JR, 32'h0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    checks++;
    if (StallCycles !== 16'hFFFE)
      $display("[TB] FAIL sat_fffe: got %h expected fffe", StallCycles);
    else passes++;
    tick();
    checks++;
    if (StallCycles !== 16'hFFFF)
      $display("[TB] FAIL sat_ffff: got %h expected ffff", StallCycles);
    else passes++;
    tick();
    tick();
    checks++;
    if (StallCycles !== 16'hFFFF || Stall !== 1'b1)
      $display("[TB] FAIL sat_hold: got cnt=%h stall=%0b expected ffff/1", StallCycles, Stall);
    else passes++;
    EXMEM_MemRead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_jr_after_load();
    test_jr_load_mem();
    test_zero_reg();
    test_flush_priority();
    test_reset_in_hold();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
